// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX forwarding, load-use stall, redirect flush and multi-cycle op sequencer.
// Optional HAZARD_PERF_EN adds stall/flush event counters.  Rev 1.0
`default_nettype none

module ex_hazard_ctrl #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = $clog2(MC_CYCLES)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] Rs1D_i,
  input  logic [4:0] Rs2D_i,
  input  logic [4:0] Rs1E_i,
  input  logic [4:0] Rs2E_i,
  input  logic [4:0] RdE_i,
  input  logic [1:0] WriteSrcE_i,
  input  logic       MultiCycleE_i,
  input  logic [4:0] RdM_i,
  input  logic       RegWriteM_i,
  input  logic       PCSrcM_i,
  input  logic [4:0] RdW_i,
  input  logic       RegWriteW_i,
  output logic [1:0] ForwardAE_o,
  output logic [1:0] ForwardBE_o,
  output logic       StallF_o,
  output logic       StallD_o,
  output logic       StallE_o,
  output logic       FlushD_o,
  output logic       FlushE_o,
  output logic       FlushM_o,
  output logic       ExStart_o,
  output logic       ExBusy_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCnt_o,
  output logic [31:0] FlushCnt_o
`endif
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == rs))
      return 2'b10;
    else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign lw_stall = (WriteSrcE_i == 2'b01) && (RdE_i != 5'd0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  always_comb begin
    ForwardAE_o = fwd_sel(Rs1E_i);
    ForwardBE_o = fwd_sel(Rs2E_i);
    StallF_o    = 1'b0;
    StallD_o    = 1'b0;
    StallE_o    = 1'b0;
    FlushD_o    = 1'b0;
    FlushE_o    = 1'b0;
    FlushM_o    = 1'b0;
    ExStart_o   = 1'b0;
    ExBusy_o    = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (!rst_ni) begin
      ForwardAE_o = 2'b00;
      ForwardBE_o = 2'b00;
      FlushD_o    = 1'b1;
      FlushE_o    = 1'b1;
      FlushM_o    = 1'b1;
      state_d     = RUN;
      cnt_d       = '0;
    end else if (PCSrcM_i) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
      FlushM_o = 1'b1;
      state_d  = RUN;
      cnt_d    = '0;
    end else if (state_q == BUSY) begin
      // Load-use is masked here: F/D are already held until release.
      if (cnt_q != '0) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        StallE_o = 1'b1;
        FlushM_o = 1'b1;
        ExBusy_o = 1'b1;
        cnt_d    = cnt_q - 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (MultiCycleE_i) begin
      StallF_o  = 1'b1;
      StallD_o  = 1'b1;
      StallE_o  = 1'b1;
      FlushM_o  = 1'b1;
      ExStart_o = 1'b1;
      state_d   = BUSY;
      cnt_d     = CNT_W'(MC_CYCLES - 2);
    end else if (lw_stall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, StallF_o};
    flush_cnt_d = flush_cnt_q + {31'd0, PCSrcM_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`endif

endmodule

`default_nettype wire
